// File: rtl/bram_burst_port_master.sv
// Burst initiator for a 32-bit BRAM port: turns word-burst commands into single-cycle
// BRAM accesses and streams read data back through a small response FIFO.
module bram_burst_port_master #(
  parameter int unsigned C_MEMSIZE     = 'h4000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_LEN_W       = 8,
  parameter int unsigned C_RSP_DEPTH   = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [0:C_PORT_AWIDTH-1] cmd_addr,
  input  logic [C_LEN_W-1:0]       cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [0:C_PORT_DWIDTH-1] wr_data,
  input  logic [0:C_NUM_WE-1]      wr_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [0:C_PORT_DWIDTH-1] rsp_data,
  output logic                     rsp_last,
  output logic                     cmd_done,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din,
  output logic                     BRAM_Rst
);
  localparam int AW        = C_PORT_AWIDTH;
  localparam int PW        = $clog2(C_RSP_DEPTH);
  localparam int CW        = PW + 2;
  localparam int NB        = C_LEN_W + 1;
  localparam int RD_STAGES = 2;
  localparam logic [0:AW-1] OFF_MASK   = AW'(C_MEMSIZE - 1);
  localparam logic [0:AW-1] ALIGN_MASK = ~AW'(3);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;
  typedef struct packed {
    logic                     last;
    logic [0:C_PORT_DWIDTH-1] data;
  } rsp_t;

  state_t               state, state_nxt;
  logic [0:AW-1]        cur, cur_nxt;
  logic [NB-1:0]        beats;
  logic [RD_STAGES:1]   vld_pipe, last_pipe;
  rsp_t                 fifo_mem [C_RSP_DEPTH];
  rsp_t                 head;
  logic [PW-1:0]        wptr, rptr;
  logic [PW:0]          fifo_count;
  logic [CW-1:0]        occ;
  logic                 cmd_acc, wr_acc, wr_last, rd_issue, push, pop, rd_done;

  assign cmd_acc  = cmd_valid & cmd_ready;
  assign wr_acc   = wr_valid & wr_ready;
  assign wr_last  = wr_acc && (beats == NB'(1));
  // Reads in flight already own a FIFO slot, so they count against the depth.
  assign occ      = CW'(fifo_count) + CW'(vld_pipe[1]) + CW'(vld_pipe[2]);
  assign rd_issue = (state == RD) && (beats != '0) && (occ < CW'(C_RSP_DEPTH));
  assign push     = vld_pipe[RD_STAGES];
  assign head     = fifo_mem[rptr];
  assign rsp_valid = (fifo_count != '0);
  assign pop      = rsp_valid & rsp_ready;
  assign rd_done  = (state == RD) && pop && head.last;
  assign rsp_data = head.data;
  assign rsp_last = rsp_valid & head.last;
  assign BRAM_Rst = 1'b0;
  // Offset wraps inside the memory window; base bits above it are held.
  assign cur_nxt  = (cur & ~OFF_MASK) | ((cur + AW'(4)) & OFF_MASK);

  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_acc) state_nxt = cmd_write ? WR : RD;
      WR:      if (wr_last) state_nxt = IDLE;
      RD:      if (rd_done) state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE:    cmd_ready = BRAM_Rst_N;
      WR:      wr_ready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      cur       <= '0;
      beats     <= '0;
      cmd_done  <= 1'b0;
      BRAM_EN   <= 1'b0;
      BRAM_WEN  <= '0;
      BRAM_Addr <= '0;
      BRAM_Dout <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      cmd_done  <= wr_last | rd_done;
      BRAM_EN   <= 1'b0;
      BRAM_WEN  <= '0;
      vld_pipe  <= {vld_pipe[RD_STAGES-1:1], rd_issue};
      last_pipe <= {last_pipe[RD_STAGES-1:1], rd_issue && (beats == NB'(1))};
      if (cmd_acc) begin
        cur   <= cmd_addr & ALIGN_MASK;
        beats <= NB'(cmd_len) + NB'(1);
      end
      if (wr_acc) begin
        BRAM_EN   <= 1'b1;
        BRAM_WEN  <= wr_be;
        BRAM_Dout <= wr_data;
        BRAM_Addr <= cur;
        cur       <= cur_nxt;
        beats     <= beats - NB'(1);
      end
      if (rd_issue) begin
        BRAM_EN   <= 1'b1;
        BRAM_Addr <= cur;
        cur       <= cur_nxt;
        beats     <= beats - NB'(1);
      end
    end
  end

  // Din belongs to the access issued two edges earlier.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      for (int i = 0; i < int'(C_RSP_DEPTH); i++) fifo_mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= {last_pipe[RD_STAGES], BRAM_Din};
        wptr           <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_port_master.sv
// Scoreboard bench for bram_burst_port_master: a BRAM model answers the port, a reference
// memory and address formula predict every BRAM access and every read response.
`timescale 1ns/1ps
module tb_bram_burst_port_master;
  localparam int MEMSIZE = 'h4000;
  localparam int NWORDS  = MEMSIZE / 4;
  localparam logic [0:31] OMASK = 32'(MEMSIZE - 1);

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [0:31] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [0:31] wr_data;
  logic [0:3]  wr_be;
  logic        rsp_valid, rsp_ready, rsp_last, cmd_done;
  logic [0:31] rsp_data;
  logic        BRAM_EN, BRAM_Rst;
  logic [0:3]  BRAM_WEN;
  logic [0:31] BRAM_Addr, BRAM_Dout, BRAM_Din;

  always #5 clk = ~clk;

  bram_burst_port_master dut (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .cmd_done(cmd_done),
    .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr),
    .BRAM_Dout(BRAM_Dout), .BRAM_Din(BRAM_Din), .BRAM_Rst(BRAM_Rst)
  );

  typedef struct {logic [0:31] addr; logic [0:3] wen; logic [0:31] dout; bit is_wr;} acc_t;
  typedef struct {logic [0:31] data; logic last;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int errors = 0, checks = 0;
  int done_cnt = 0, exp_done = 0, en_cnt = 0;
  int en_run = 0, last_en_run = 0, pop_run = 0, last_pop_run = 0;
  int rsp_mode = 0;

  function automatic int widx(input logic [0:31] a);
    return int'((a & OMASK) >> 2);
  endfunction
  function automatic logic [0:31] seed_word(input int i);
    return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A_1234;
  endfunction
  // Address of beat b: aligned start plus 4*b, offset wrapping inside MEMSIZE.
  function automatic logic [0:31] beat_addr(input logic [0:31] start, input int b);
    logic [0:31] base;
    base = start & ~32'h3;
    return (base & ~OMASK) | ((base + 32'(4 * b)) & OMASK);
  endfunction

  // BRAM model, one-cycle read latency
  logic [0:31] bram [NWORDS];
  bit          bram_init = 1'b0;
  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < NWORDS; i++) bram[i] <= seed_word(i);
      bram_init <= 1'b1;
    end else if (BRAM_EN) begin
      BRAM_Din <= bram[widx(BRAM_Addr)];
      for (int i = 0; i < 4; i++)
        if (BRAM_WEN[i]) bram[widx(BRAM_Addr)][8*i +: 8] <= BRAM_Dout[8*i +: 8];
    end
  end

  logic [0:31] ref_mem [NWORDS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a BRAM access or a response
  initial begin
    acc_t a;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
        rsp_q.delete();
        en_run = 0;
        pop_run = 0;
      end else begin
        if (cmd_done) done_cnt++;
        if (BRAM_EN) begin
          en_cnt++;
          en_run++;
          if (acc_q.size() == 0) fail("bram_unexpected_access");
          else begin
            a = acc_q.pop_front();
            chk("bram_addr", BRAM_Addr, a.addr);
            chk("bram_wen", BRAM_WEN, a.wen);
            if (a.is_wr) chk("bram_dout", BRAM_Dout, a.dout);
          end
        end else begin
          if (en_run > 0) last_en_run = en_run;
          en_run = 0;
          chk("wen_idle", BRAM_WEN, 0);
        end
        if (rsp_valid && rsp_ready) begin
          pop_run++;
          if (rsp_q.size() == 0) fail("rsp_unexpected");
          else begin
            r = rsp_q.pop_front();
            chk("rsp_data", rsp_data, r.data);
            chk("rsp_last", rsp_last, r.last);
          end
        end else begin
          if (pop_run > 0) last_pop_run = pop_run;
          pop_run = 0;
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input logic [0:31] addr, input int len);
    int n;
    bit ok;
    acc_t a;
    rsp_t r;
    n = 0;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!ok) fail("cmd_accept_timeout");
    else begin
      exp_done++;
      if (!wr) begin
        for (int b = 0; b <= len; b++) begin
          a.addr = beat_addr(addr, b); a.wen = '0; a.dout = '0; a.is_wr = 1'b0;
          acc_q.push_back(a);
          r.data = ref_mem[widx(a.addr)]; r.last = (b == len);
          rsp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic write_burst(input logic [0:31] addr, input int len, input bit rnd,
                             input logic [0:3] be_in, input bit gaps);
    logic [0:31] d;
    logic [0:3]  be;
    int n;
    bit ok;
    acc_t a;
    issue_cmd(1'b1, addr, len);
    for (int b = 0; b <= len; b++) begin
      d  = rnd ? 32'($urandom) : 32'hA0 + 32'(b);
      be = rnd ? 4'($urandom) : be_in;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      wr_valid = 1'b1; wr_data = d; wr_be = be;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 100) begin
        @(negedge clk);
        ok = wr_ready;
        tick();
        n++;
      end
      wr_valid = 1'b0;
      if (!ok) begin
        fail("wr_accept_timeout");
        break;
      end
      a.addr = beat_addr(addr, b); a.wen = be; a.dout = d; a.is_wr = 1'b1;
      acc_q.push_back(a);
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[widx(a.addr)][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 2000) begin
      tick();
      n++;
    end
    if (done_cnt < exp_done) fail("done_timeout");
    repeat (3) tick();
  endtask

  initial begin
    int e0, d0, n;
    logic [0:31] addr;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = seed_word(i);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_en", BRAM_EN, 0);
    chk("reset_wen", BRAM_WEN, 0);
    chk("reset_addr", BRAM_Addr, 0);
    chk("reset_dout", BRAM_Dout, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_last", rsp_last, 0);
    chk("reset_cmd_done", cmd_done, 0);
    chk("bram_rst", BRAM_Rst, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    tick();

    // 1: write 0xA0..0xA3 at 0x100
    write_burst(32'h100, 3, 1'b0, 4'hF, 1'b0);
    wait_done();
    chk("t1_done_count", done_cnt, exp_done);
    chk("t1_en_run", last_en_run, 4);

    // 2: read back at full rate
    rsp_mode = 0;
    issue_cmd(1'b0, 32'h100, 3);
    wait_done();
    chk("t2_en_run", last_en_run, 4);
    chk("t2_pop_run", last_pop_run, 4);
    chk("t2_done_count", done_cnt, exp_done);

    // 3: back-pressure stops issue once the FIFO is spoken for
    rsp_mode = 2;
    e0 = en_cnt;
    issue_cmd(1'b0, 32'h200, 7);
    repeat (10) tick();
    @(negedge clk);
    chk("t3_en_pulses", en_cnt - e0, 4);
    chk("t3_en_low", BRAM_EN, 0);
    chk("t3_rsp_valid", rsp_valid, 1);
    rsp_mode = 0;
    wait_done();
    chk("t3_en_total", en_cnt - e0, 8);
    chk("t3_done_count", done_cnt, exp_done);

    // 4: wrap at the top of the memory window
    write_burst(32'h3FFC, 1, 1'b0, 4'b0110, 1'b0);
    wait_done();
    chk("t4_done_count", done_cnt, exp_done);

    // 5: reset during the third read beat
    d0 = done_cnt;
    e0 = en_cnt;
    issue_cmd(1'b0, 32'h300, 7);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (en_cnt - e0 < 3 && n < 50);
    if (en_cnt - e0 < 3) fail("t5_third_beat_timeout");
    rst_n = 1'b0;
    #1;
    chk("t5_en_async_drop", BRAM_EN, 0);
    exp_done = d0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    repeat (10) tick();
    chk("t5_no_done", done_cnt, d0);

    // 6: misaligned start address
    read_then_write: begin
      issue_cmd(1'b0, 32'h103, 0);
      wait_done();
      write_burst(32'h107, 1, 1'b1, 4'hF, 1'b0);
      wait_done();
    end

    // random traffic
    for (int k = 0; k < 40; k++) begin
      addr = 32'($urandom);
      addr = (addr & ~OMASK) | (($urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 'h1FF))
                                                           : 32'h3F00 + 32'($urandom_range(0, 'hFF))) & OMASK);
      rsp_mode = $urandom_range(0, 1);
      n = (k == 20) ? 255 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) write_burst(addr, n, 1'b1, 4'hF, 1'($urandom_range(0, 1)));
      else issue_cmd(1'b0, addr, n);
      wait_done();
    end
    rsp_mode = 0;
    chk("final_done_count", done_cnt, exp_done);
    chk("final_acc_q_empty", acc_q.size(), 0);
    chk("final_rsp_q_empty", rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
